// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter: FSM state type and
// default clock/baud constants.
package uart_pkg;

    localparam int unsigned CLK_FREQ_DEFAULT = 12_000_000;
    localparam int unsigned BAUD_DEFAULT     = 115_200;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_e;

    // Bit period in clock cycles, integer truncation.
    function automatic int unsigned calc_div(input int unsigned clk_freq,
                                             input int unsigned baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter. Writes while full are ignored here;
// the parent flags them. Pointers wrap modulo DEPTH (power of two).
module uart_tx_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       full,
    output logic       empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push;
    logic          pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign rd_data = mem_q[rd_ptr_q];

    // Next-state for storage, pointers and occupancy count.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers; reset empties the FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/uart_tx_buf.sv
// Buffered UART transmitter: 8N1 frames, LSB first, fed from a small FIFO.
// Frames are sent back to back while bytes are queued.
module uart_tx_buf
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = CLK_FREQ_DEFAULT,
    parameter int unsigned BAUD     = BAUD_DEFAULT,
    parameter int unsigned DEPTH    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_data_rdy,
    output logic       tx,
    output logic       busy,
    output logic       full,
    output logic       overflow
);

    localparam int unsigned DIV   = calc_div(CLK_FREQ, BAUD);
    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    uart_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             ovf_q, ovf_d;

    logic             fifo_pop;
    logic [7:0]       fifo_rd_data;
    logic             fifo_full;
    logic             fifo_empty;

    uart_tx_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (tx_data_rdy),
        .wr_data(tx_data),
        .rd_en  (fifo_pop),
        .rd_data(fifo_rd_data),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign tx       = tx_q;
    assign busy     = (state_q != IDLE);
    assign full     = fifo_full;
    assign overflow = ovf_q;

    // Frame sequencing: baud timing, bit selection and FIFO pops.
    // tx_d carries the value for the upcoming bit so tx comes straight from a flop.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        fifo_pop  = 1'b0;
        ovf_d     = ovf_q | (tx_data_rdy & fifo_full);

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                tx_d  = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_rd_data;
                    state_d  = START;
                    tx_d     = 1'b0;
                end
            end
            START: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = DATA;
                    tx_d      = shift_q[0];
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_d      = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_rd_data;
                        state_d  = START;
                        tx_d     = 1'b0;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                tx_d    = 1'b1;
            end
        endcase
    end

    // State registers; reset aborts any frame and releases the line high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            ovf_q     <= ovf_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_buf.sv
// Self-checking bench for uart_tx_buf: transaction-level reference model of the
// queue and frame timeline, compared against the DUT every cycle.
module tb_uart_tx_buf;

    localparam int DIV   = 104;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       s1 = 1'b0, s3 = 1'b0;
    logic [7:0] d1 = '0, d3 = '0;
    logic       tx1, busy1, full1, ovf1;
    logic       tx3, busy3, full3, ovf3;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    uart_tx_buf #(.CLK_FREQ(12000000), .BAUD(115200), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .tx_data(d1), .tx_data_rdy(s1),
        .tx(tx1), .busy(busy1), .full(full1), .overflow(ovf1)
    );

    uart_tx_buf #(.CLK_FREQ(1000), .BAUD(300), .DEPTH(4)) dut3 (
        .clk(clk), .rst(rst), .tx_data(d3), .tx_data_rdy(s3),
        .tx(tx3), .busy(busy3), .full(full3), .overflow(ovf3)
    );

    // Reference model: queue of waiting bytes plus the start cycle of the
    // frame on the line; line level derived from elapsed time within a frame.
    logic [7:0] mq[$];
    bit         m_act;
    logic [7:0] m_cur;
    int         m_cyc, m_fs;
    bit         m_ovf, m_tx = 1'b1, m_busy, m_full;

    task automatic model_reset();
        mq.delete();
        m_act = 0; m_cyc = 0; m_fs = 0;
        m_ovf = 0; m_tx = 1; m_busy = 0; m_full = 0;
    endtask

    task automatic model_edge(input bit stb, input logic [7:0] dat);
        int size0;
        int b;
        bit acc;
        m_cyc++;
        size0 = mq.size();
        acc   = stb && (size0 < DEPTH);
        if (stb && !acc) m_ovf = 1;
        if (m_act && (m_cyc - m_fs) == 10 * DIV) m_act = 0;
        if (!m_act && size0 > 0) begin
            m_cur = mq.pop_front();
            m_act = 1;
            m_fs  = m_cyc;
        end
        if (acc) mq.push_back(dat);
        m_tx = 1;
        if (m_act) begin
            b = (m_cyc - m_fs) / DIV;
            if (b == 0) m_tx = 0;
            else if (b <= 8) m_tx = m_cur[b-1];
        end
        m_busy = m_act;
        m_full = (mq.size() == DEPTH);
    endtask

    task automatic step(input bit stb1, input logic [7:0] dat1,
                        input bit stb3, input logic [7:0] dat3);
        @(negedge clk);
        s1 = stb1; d1 = dat1; s3 = stb3; d3 = dat3;
        @(posedge clk);
        model_edge(stb1, dat1);
        #1;
        s1 = 1'b0; s3 = 1'b0;
    endtask

    function automatic logic [3:0] obs1();
        return {tx1, busy1, full1, ovf1};
    endfunction

    function automatic logic [3:0] exp1();
        return {m_tx, m_busy, m_full, m_ovf};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (obs1() !== 4'b1000) begin
            errors++;
            $display("FAIL reset_state dut got tx/busy/full/ovf=%b expected=1000", obs1());
        end
        checks++;
        if ({tx3, busy3, full3, ovf3} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_state dut3 got tx/busy/full/ovf=%b expected=1000", {tx3, busy3, full3, ovf3});
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_single();
        step(1, 8'h41, 0, 8'h00);
        for (int j = 0; j < 1050; j++) begin
            step(0, 8'h00, 0, 8'h00);
            checks++;
            if (obs1() !== exp1()) begin
                errors++;
                $display("FAIL single cyc=%0d got tx/busy/full/ovf=%b expected=%b", j, obs1(), exp1());
            end
            if (j == 0 || j == 1039 || j == 1040) begin
                checks++;
                if ({tx1, busy1} !== ((j == 0) ? 2'b01 : (j == 1039) ? 2'b11 : 2'b10)) begin
                    errors++;
                    $display("FAIL single_edge j=%0d got tx/busy=%b%b", j, tx1, busy1);
                end
            end
        end
    endtask

    task automatic test_burst();
        int busy_cycles = 0;
        step(1, 8'h31, 0, 8'h00);
        step(1, 8'h32, 0, 8'h00);
        if (busy1) busy_cycles++;
        step(1, 8'h33, 0, 8'h00);
        if (busy1) busy_cycles++;
        for (int j = 0; j < 3140; j++) begin
            step(0, 8'h00, 0, 8'h00);
            if (busy1) busy_cycles++;
            checks++;
            if (obs1() !== exp1()) begin
                errors++;
                $display("FAIL burst cyc=%0d got tx/busy/full/ovf=%b expected=%b", j, obs1(), exp1());
            end
        end
        checks++;
        if (busy_cycles !== 3120) begin
            errors++;
            $display("FAIL burst_span got %0d busy cycles expected 3120", busy_cycles);
        end
    endtask

    task automatic test_overflow();
        int busy_cycles = 0;
        for (int k = 0; k < 6; k++) begin
            step(1, 8'($urandom), 0, 8'h00);
            if (busy1) busy_cycles++;
            checks++;
            if (obs1() !== exp1()) begin
                errors++;
                $display("FAIL overflow_fill k=%0d got tx/busy/full/ovf=%b expected=%b", k, obs1(), exp1());
            end
        end
        for (int j = 0; j < 5220; j++) begin
            step(0, 8'h00, 0, 8'h00);
            if (busy1) busy_cycles++;
            checks++;
            if (obs1() !== exp1()) begin
                errors++;
                $display("FAIL overflow cyc=%0d got tx/busy/full/ovf=%b expected=%b", j, obs1(), exp1());
            end
        end
        checks++;
        if (busy_cycles !== 5200 || ovf1 !== 1'b1) begin
            errors++;
            $display("FAIL overflow_total got busy=%0d ovf=%b expected busy=5200 ovf=1", busy_cycles, ovf1);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (ovf1 !== 1'b0) begin
            errors++;
            $display("FAIL overflow_clear got ovf=%b expected=0", ovf1);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_full_pop();
        int guard = 0;
        for (int k = 0; k < 5; k++) step(1, 8'($urandom), 0, 8'h00);
        while ((m_cyc + 1 - m_fs) != 10 * DIV && guard < 2000) begin
            step(0, 8'h00, 0, 8'h00);
            guard++;
            checks++;
            if (obs1() !== exp1()) begin
                errors++;
                $display("FAIL full_pop_wait cyc=%0d got tx/busy/full/ovf=%b expected=%b", guard, obs1(), exp1());
            end
        end
        checks++;
        if (guard >= 2000 || {full1, ovf1} !== 2'b10) begin
            errors++;
            $display("FAIL full_pop_pre got full/ovf=%b%b guard=%0d expected full=1 ovf=0", full1, ovf1, guard);
        end
        step(1, 8'hee, 0, 8'h00);
        checks++;
        if ({ovf1, full1} !== 2'b10) begin
            errors++;
            $display("FAIL full_pop_drop got ovf/full=%b%b expected=10", ovf1, full1);
        end
        for (int j = 0; j < 4180; j++) begin
            step(0, 8'h00, 0, 8'h00);
            checks++;
            if (obs1() !== exp1()) begin
                errors++;
                $display("FAIL full_pop cyc=%0d got tx/busy/full/ovf=%b expected=%b", j, obs1(), exp1());
            end
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset_mid();
        int guard = 0;
        step(1, 8'h5a, 0, 8'h00);
        step(1, 8'hc3, 0, 8'h00);
        step(1, 8'h7e, 0, 8'h00);
        while ((m_cyc - m_fs) != 300 && guard < 1000) begin
            step(0, 8'h00, 0, 8'h00);
            guard++;
            checks++;
            if (obs1() !== exp1()) begin
                errors++;
                $display("FAIL reset_mid_pre cyc=%0d got tx/busy/full/ovf=%b expected=%b", guard, obs1(), exp1());
            end
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (obs1() !== 4'b1000 || guard >= 1000) begin
            errors++;
            $display("FAIL reset_mid_abort got tx/busy/full/ovf=%b expected=1000", obs1());
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int j = 0; j < 20; j++) begin
            step(0, 8'h00, 0, 8'h00);
            checks++;
            if (obs1() !== 4'b1000) begin
                errors++;
                $display("FAIL reset_mid_empty cyc=%0d got tx/busy/full/ovf=%b expected=1000", j, obs1());
            end
        end
        step(1, 8'h1b, 0, 8'h00);
        for (int j = 0; j < 1050; j++) begin
            step(0, 8'h00, 0, 8'h00);
            checks++;
            if (obs1() !== exp1()) begin
                errors++;
                $display("FAIL reset_mid_after cyc=%0d got tx/busy/full/ovf=%b expected=%b", j, obs1(), exp1());
            end
        end
    endtask

    task automatic test_random();
        int guard = 0;
        for (int j = 0; j < 4000; j++) begin
            step(($urandom_range(0, 249) == 0) || (j >= 2000 && j < 2006), 8'($urandom), 0, 8'h00);
            checks++;
            if (obs1() !== exp1()) begin
                errors++;
                $display("FAIL random cyc=%0d got tx/busy/full/ovf=%b expected=%b", j, obs1(), exp1());
            end
        end
        while ((m_act || mq.size() > 0) && guard < 6000) begin
            step(0, 8'h00, 0, 8'h00);
            guard++;
            checks++;
            if (obs1() !== exp1()) begin
                errors++;
                $display("FAIL random_drain cyc=%0d got tx/busy/full/ovf=%b expected=%b", guard, obs1(), exp1());
            end
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_divisor();
        logic [7:0] b0, b1, cur;
        int         f, b;
        logic [1:0] e;
        b0 = 8'($urandom);
        b1 = 8'($urandom);
        step(0, 8'h00, 1, b0);
        step(0, 8'h00, 1, b1);
        for (int j = 0; j < 66; j++) begin
            if (j > 0) step(0, 8'h00, 0, 8'h00);
            e = 2'b10;
            if (j < 60) begin
                f   = j / 30;
                b   = (j % 30) / 3;
                cur = (f == 0) ? b0 : b1;
                e   = {(b == 0) ? 1'b0 : (b <= 8) ? cur[b-1] : 1'b1, 1'b1};
            end
            checks++;
            if ({tx3, busy3} !== e) begin
                errors++;
                $display("FAIL divisor j=%0d got tx/busy=%b%b expected=%b", j, tx3, busy3, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_overflow();
        test_full_pop();
        test_reset_mid();
        test_random();
        test_divisor();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout simulation exceeded time limit");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/uart_tx_buf.md
UART_TX_BUF -- requirements
Module: uart_tx_buf

Interface
REQ-001 Parameter CLK_FREQ, default 12000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, serial bit rate.
REQ-003 Parameter DEPTH, default 4, FIFO depth in bytes; power of two, at least 2.
REQ-004 clk  input  1  system clock; the only clock.
REQ-005 rst  input  1  reset; asynchronous, active-high.
REQ-006 tx_data  input  8  byte to transmit; sampled only when tx_data_rdy=1.
REQ-007 tx_data_rdy  input  1  one-cycle write strobe.
REQ-008 tx  output  1  serial line; idles high.
REQ-009 busy  output  1  high while a frame is being shifted out (START, DATA or STOP state).
REQ-010 full  output  1  FIFO holds DEPTH bytes.
REQ-011 overflow  output  1  sticky; a write was dropped.

Function
REQ-012 The bit period SHALL be DIV = CLK_FREQ/BAUD clock cycles, using integer truncation (104 at the defaults).
REQ-013 Each frame SHALL be one start bit (0), 8 data bits LSB first, and one stop bit (1), each exactly DIV cycles; a frame is 10*DIV cycles.
REQ-014 A strobe while full=0 SHALL push tx_data into the FIFO at that clock edge.
REQ-015 A strobe while full=1 SHALL drop the byte and set overflow; full is evaluated before any same-cycle pop.
REQ-016 overflow SHALL clear only on rst.
REQ-017 The FSM SHALL use the states IDLE, START, DATA and STOP.
REQ-018 IDLE: when the FIFO is non-empty, pop the head into the shift register, go to START and drive tx=0.
REQ-019 START: after DIV cycles, go to DATA with bit index 0.
REQ-020 DATA: every DIV cycles, advance the bit index; after bit 7 completes, go to STOP.
REQ-021 STOP: after DIV cycles, go to START if the FIFO is non-empty (pop in the same cycle; no idle gap), otherwise go to IDLE.
REQ-022 Latency: for a strobe at edge N into an empty FIFO with the FSM in IDLE, tx SHALL be 0 from edge N+1.
REQ-023 A push and a pop in the same cycle SHALL leave the FIFO count unchanged and order preserved.
REQ-024 The FIFO read and write pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH.
REQ-025 tx SHALL be registered (glitch-free) and SHALL equal 1 in IDLE.
REQ-026 Input bytes are not modified; transmitted order SHALL equal accepted write order.

Reset
REQ-027 rst=1 SHALL asynchronously force: FSM to IDLE, tx=1, busy=0, full=0, overflow=0, FIFO empty, all counters 0.
REQ-028 rst asserted mid-frame SHALL abort the frame immediately, drive tx high, and discard all queued bytes.
REQ-029 After rst deasserts, the first strobe SHALL behave exactly as in REQ-022.

Structure
REQ-030 A shared package uart_pkg SHALL hold the FSM state enum and the default CLK_FREQ and BAUD constants.
REQ-031 The FIFO SHALL be a sub-module, uart_tx_fifo (parameter DEPTH, width 8, outputs full and empty), instantiated once.
REQ-032 The baud counter, bit index and shift register SHALL reside in uart_tx_buf.

Verification
REQ-033 Single byte: write 8'h41 in idle -> tx low 1 cycle after the strobe; bits 1,0,0,0,0,0,1,0 each 104 cycles; stop high; busy low after 1040 cycles.
REQ-034 Burst: write 8'h31, 8'h32, 8'h33 on consecutive cycles -> three back-to-back frames spanning 3120 cycles, no idle between stop and start, correct order.
REQ-035 Overflow: with DEPTH=4, write 6 bytes during the first frame -> 5 bytes transmitted (1 in flight + 4 queued), 1 dropped, overflow=1 held until rst.
REQ-036 Full and pop same cycle: write while full=1 on the cycle of the stop-to-start pop -> byte dropped and overflow set.
REQ-037 Reset mid-frame: assert rst at cycle 300 of a frame -> tx=1 and busy=0 within the same cycle; FIFO empty; next write 8'h1b transmits correctly.
REQ-038 Divisor: CLK_FREQ=1000, BAUD=300 -> DIV=3; verify each bit lasts 3 cycles.
